mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Port clk, input, 1 bit: single rising-edge clock; all state SHALL change only on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous active-high reset, sampled at the clk rising edge.
REQ-004 Port start, input, 1 bit: E-stage instruction is a mult/div/mthi/mtlo; valid for one cycle.
REQ-005 Port cancel, input, 1 bit: E-stage instruction is being flushed (exception/interrupt); overrides start.
REQ-006 Port op, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 SHALL be treated as no-op.
REQ-007 Port A, input, 32 bits: rs operand (forwarded value).
REQ-008 Port B, input, 32 bits: rt operand (forwarded value).
REQ-009 Port busy, output, 1 bit: operation in flight; consumed by hazardmonitor stall_md logic.
REQ-010 Port hi, output, 32 bits: architectural HI register.
REQ-011 Port lo, output, 32 bits: architectural LO register.
REQ-012 Parameters MUL_CYCLES, default 5: busy cycles for mult/multu; DIV_CYCLES, default 10: busy cycles for div/divu.

Function
REQ-013 An operation SHALL be accepted at a clk edge only when start=1, cancel=0, reset=0 and state is IDLE.
REQ-014 The FSM SHALL have states IDLE, MUL and DIV; IDLE->MUL on accepted mult/multu, IDLE->DIV on accepted div/divu, MUL/DIV->IDLE when the cycle counter expires.
REQ-015 On acceptance, operands and op SHALL be latched internally; later changes on A, B or op SHALL NOT affect the result.
REQ-016 busy SHALL be registered: 1 for exactly MUL_CYCLES (or DIV_CYCLES) cycles starting the cycle after the accepting edge, then 0.
REQ-017 hi/lo SHALL update at the edge that ends the last busy cycle; the new values SHALL be visible in the same cycle busy first reads 0.
REQ-018 mult SHALL form the signed 64-bit product; multu the unsigned 64-bit product; hi = bits 63:32, lo = bits 31:0.
REQ-019 div/divu SHALL set lo = quotient and hi = remainder; signed division truncates toward zero, remainder takes the sign of the dividend.
REQ-020 When the divisor is 0, div/divu SHALL still hold busy for DIV_CYCLES, and hi/lo SHALL retain their prior values.
REQ-021 mthi/mtlo SHALL write A into hi/lo at the accepting edge, with no busy cycle and the other register unchanged.
REQ-022 start while busy=1 SHALL be ignored, with no state change and the in-flight result unaffected.
REQ-023 start with cancel=1 SHALL be ignored in every state.
REQ-024 No-op codes (110/111) SHALL cause no state change and no busy.
REQ-025 Internal counter width SHALL cover max(MUL_CYCLES, DIV_CYCLES); counting SHALL NOT wrap.

Reset
REQ-026 With reset=1 at an edge, the next state SHALL be IDLE, with busy=0, hi=0, lo=0 and the counter cleared.
REQ-027 Reset SHALL take priority over start and over an expiring operation; an operation interrupted mid-flight SHALL never update hi/lo.

Verification
REQ-028 mult A=0xFFFFFFFF, B=0x00000002 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-029 div A=0xFFFFFFF9 (-7), B=0x00000002 -> busy=1 for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-030 hi=0x11111111, lo=0x22222222, then divu B=0 -> busy=1 for 10 cycles, then hi/lo unchanged.
REQ-031 mthi A=0x12345678 -> hi=0x12345678 next cycle, lo unchanged, busy never 1; mtlo behaves symmetrically.
REQ-032 div started, reset asserted during busy cycle 3 -> busy=0, hi=lo=0 next cycle; no later hi/lo change.
REQ-033 start=1 with cancel=1 -> busy stays 0 and hi/lo unchanged; mult start during an in-flight div -> ignored, and the div result matches REQ-029.

Source files
------------

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multiply/divide unit that owns the architectural HI/LO registers.
// mult/multu and div/divu are accepted from the E stage. Busy is then held for a
// fixed number of cycles, and HI/LO are written at the edge that ends the last
// busy cycle. mthi/mtlo write HI/LO directly at the accepting edge.
//
// Ports
//   clk     : rising-edge clock
//   reset   : synchronous, active-high reset
//   start   : E-stage instruction is a mult/div/mthi/mtlo (one-cycle pulse)
//   cancel  : E-stage instruction is being flushed; overrides start
//   op      : 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo,
//             110/111 no-op
//   A, B    : rs / rt operands (forwarded values)
//   busy    : operation in flight (registered)
//   hi, lo  : architectural HI / LO registers
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP6  = 3'b110,
        OP_NOP7  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Down-counter loaded with N-1 on acceptance. The operation completes on
    // the edge where it reads zero, so busy spans exactly N cycles and the
    // counter never decrements past zero.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    op_e              op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;

    // ------------------------------------------------------------------
    // Result datapath, driven only by the latched operands. The operands
    // are stable for the whole busy window, so this logic may be treated as
    // a multicycle path of MUL_CYCLES / DIV_CYCLES.
    // ------------------------------------------------------------------
    logic        mul_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // NOTE: every signal assigned in always_comb gets a default at the top,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        mul_signed = (op_q == OP_MULT);
        // Low 64 bits of a 64x64 product of sign- or zero-extended operands
        // equal the signed or unsigned 32x32 product respectively.
        a_ext = {{32{mul_signed & a_q[31]}}, a_q};
        b_ext = {{32{mul_signed & b_q[31]}}, b_q};
        prod  = a_ext * b_ext;

        // Signed division is done on magnitudes and the signs re-applied:
        // quotient truncates toward zero, remainder follows the dividend.
        // This also keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
        div_signed = (op_q == OP_DIV);
        a_neg      = div_signed & a_q[31];
        b_neg      = div_signed & b_q[31];
        a_mag      = a_neg ? (32'd0 - a_q) : a_q;
        b_mag      = b_neg ? (32'd0 - b_q) : b_q;
        q_mag      = '0;
        r_mag      = '0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem  = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // ------------------------------------------------------------------
    // Control FSM with registered busy/hi/lo.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register, operand latches included, is cleared so
            // simulation and silicon leave reset in the same known state.
            state <= IDLE;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        case (op_e'(op))
                            OP_MULT, OP_MULTU: begin
                                op_q  <= op_e'(op);
                                a_q   <= A;
                                b_q   <= B;
                                cnt   <= MUL_LOAD;
                                busy  <= 1'b1;
                                state <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q  <= op_e'(op);
                                a_q   <= A;
                                b_q   <= B;
                                cnt   <= DIV_LOAD;
                                busy  <= 1'b1;
                                state <= DIV;
                            end
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: ; // no-op codes
                        endcase
                    end
                end

                MUL: begin
                    if (cnt == '0) begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DIV: begin
                    if (cnt == '0) begin
                        // Divide by zero still consumes the full busy window
                        // but leaves HI/LO untouched.
                        if (b_q != 32'd0) begin
                            hi <= rem;
                            lo <= quot;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Scoreboard bench for mult_div_unit. The driver computes each expected HI/LO
// with plain 64-bit arithmetic and queues it together with the expected busy
// length. A separate monitor pops an entry each time busy falls (mult/div) or
// one cycle after an accepted mthi/mtlo, and compares.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cancel (cancel),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef enum {K_MD, K_MT} kind_e;
    typedef struct {
        kind_e       kind;
        int          len;
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    bit          abort_pending = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: architectural effect of one accepted operation.
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (o)
            3'd0: begin p = sa * sb; model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd1: begin p = ua * ub; model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd2: if (b != 0) begin
                sq = sa / sb; sr = sa % sb;
                model_lo = sq[31:0]; model_hi = sr[31:0];
            end
            3'd3: if (b != 0) begin
                uq = ua / ub; ur = ua % ub;
                model_lo = uq[31:0]; model_hi = ur[31:0];
            end
            3'd4: model_hi = a;
            3'd5: model_lo = a;
            default: ;
        endcase
    endtask

    // Issue one start pulse; if it is accepted, queue its expected outcome.
    // Returns on the negedge of the cycle after acceptance unless wait_done,
    // in which case it returns once the operation has completed.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input bit wait_done);
        exp_t e;
        bit   accepted;
        int   n;
        accepted = !c && (o <= 3'd5);
        n = (o <= 3'd1) ? MUL_N : ((o <= 3'd3) ? DIV_N : 0);
        @(negedge clk);
        start = 1'b1; cancel = c; op = o; A = a; B = b;
        if (accepted) begin
            model_op(o, a, b);
            e.kind = (n > 0) ? K_MD : K_MT;
            e.len  = n;
            e.due  = cyc + 1;
            e.hi   = model_hi;
            e.lo   = model_lo;
            sb_q.push_back(e);
        end
        @(negedge clk);
        // Scramble inputs so a design that fails to latch operands is caught.
        start = 1'b0; cancel = 1'b0;
        op = 3'($urandom); A = $urandom; B = $urandom;
        if (wait_done) repeat ((accepted ? n : 0) + 1) @(negedge clk);
    endtask

    // Monitor: compare queued expectations against observed DUT behaviour.
    bit prev_busy = 1'b0;
    int run_len   = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            run_len++;
        end else begin
            if (prev_busy) begin
                if (abort_pending) begin
                    abort_pending = 1'b0;
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                end else begin
                    check("md_expected_at_busy_fall",
                          64'((sb_q.size() > 0) && (sb_q[0].kind == K_MD)), 64'd1);
                    if (sb_q.size() > 0 && sb_q[0].kind == K_MD) begin
                        e = sb_q.pop_front();
                        check("md_busy_len", 64'(run_len), 64'(e.len));
                        check("md_hi", 64'(hi), 64'(e.hi));
                        check("md_lo", 64'(lo), 64'(e.lo));
                    end
                end
            end
            run_len = 0;
            if (sb_q.size() > 0 && sb_q[0].kind == K_MT && cyc >= sb_q[0].due) begin
                e = sb_q.pop_front();
                check("mt_hi", 64'(hi), 64'(e.hi));
                check("mt_lo", 64'(lo), 64'(e.lo));
                check("mt_busy", 64'(busy), 64'd0);
            end
        end
        prev_busy = (busy === 1'b1);
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int max_busy;
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);

        // Signed and unsigned multiply.
        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1);
        check("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(lo), 64'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1);
        check("multu_hi_const", 64'(hi), 64'h0000_0001);
        check("multu_lo_const", 64'(lo), 64'hFFFF_FFFE);

        // Signed and unsigned divide.
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1);
        check("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1);
        check("divu_lo_const", 64'(lo), 64'h7FFF_FFFC);
        check("divu_hi_const", 64'(hi), 64'h0000_0001);

        // mthi/mtlo, then divide by zero leaves HI/LO alone.
        run_op(3'd4, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
        run_op(3'd5, 32'h2222_2222, 32'h0, 1'b0, 1'b1);
        run_op(3'd3, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        check("div0_hi_const", 64'(hi), 64'h1111_1111);
        check("div0_lo_const", 64'(lo), 64'h2222_2222);
        run_op(3'd4, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        check("mthi_hi_const", 64'(hi), 64'h1234_5678);
        check("mthi_lo_kept", 64'(lo), 64'h2222_2222);

        // Cancelled start and no-op codes: busy never rises, HI/LO unchanged.
        run_op(3'd0, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0);
        run_op(3'd6, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0);
        run_op(3'd7, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0);
        max_busy = 0;
        repeat (MUL_N + 2) begin
            @(negedge clk);
            if (busy === 1'b1) max_busy = 1;
        end
        check("cancel_nop_no_busy", 64'(max_busy), 64'd0);
        check("cancel_nop_hi", 64'(hi), 64'(model_hi));
        check("cancel_nop_lo", 64'(lo), 64'(model_lo));

        // mult issued during an in-flight div is ignored.
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'h0000_0007; B = 32'h0000_0009;
        @(negedge clk);
        start = 1'b0;
        repeat (DIV_N) @(negedge clk);
        check("div_after_ignored_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_after_ignored_hi", 64'(hi), 64'hFFFF_FFFF);

        // Reset during busy cycle 3 of a div: everything clears, no late write.
        run_op(3'd3, 32'h0000_0064, 32'h0000_0007, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        abort_pending = 1'b1;
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        repeat (DIV_N + 3) @(negedge clk);
        check("abort_hi_later", 64'(hi), 64'd0);
        check("abort_lo_later", 64'(lo), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   1'($urandom_range(0, 7) == 0), 1'b1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        check("final_hi", 64'(hi), 64'(model_hi));
        check("final_lo", 64'(lo), 64'(model_lo));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
